// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush squash,
// decode-side writeback bypass and EX-stage operand forwarding.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              flush,
  input  logic              exm_regwrite,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_regwrite,
  input  logic [REG_W-1:0]  mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              stall,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  output logic [OP_W-1:0]   alu_op,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_store_data
);

  logic              valid_q, valid_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d, imm_q, imm_d;
  logic              alusrc_q, alusrc_d;
  logic [OP_W-1:0]   aluop_q, aluop_d;
  logic              regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;

  logic              hz;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  always_comb begin
    hz = valid_q & memread_q & (rd_q != '0) & id_valid &
         ((rd_q == id_rs) | (id_uses_rt & (rd_q == id_rt)));
  end

  assign stall = hz & ~flush;

  // Default is a bubble; a real capture happens only with no flush, no hazard.
  always_comb begin
    valid_d    = 1'b0;
    rs_d       = '0;
    rt_d       = '0;
    rd_d       = '0;
    rs_val_d   = '0;
    rt_val_d   = '0;
    imm_d      = '0;
    alusrc_d   = 1'b0;
    aluop_d    = '0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    if (!flush && !hz && id_valid) begin
      valid_d    = 1'b1;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rd_d       = id_rd;
      rs_val_d   = (mwb_regwrite && mwb_rd != '0 && mwb_rd == id_rs) ? mwb_result : id_rs_data;
      rt_val_d   = (mwb_regwrite && mwb_rd != '0 && mwb_rd == id_rt) ? mwb_result : id_rt_data;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      aluop_d    = id_aluop;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      rs_val_q   <= '0;
      rt_val_q   <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      rs_val_q   <= rs_val_d;
      rt_val_q   <= rt_val_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  // EX/MEM is the younger producer, so it takes priority over MEM/WB.
  always_comb begin
    if (exm_regwrite && exm_rd != '0 && exm_rd == rs_q)      fwd_rs = exm_result;
    else if (mwb_regwrite && mwb_rd != '0 && mwb_rd == rs_q) fwd_rs = mwb_result;
    else                                                     fwd_rs = rs_val_q;
    if (exm_regwrite && exm_rd != '0 && exm_rd == rt_q)      fwd_rt = exm_result;
    else if (mwb_regwrite && mwb_rd != '0 && mwb_rd == rt_q) fwd_rt = mwb_result;
    else                                                     fwd_rt = rt_val_q;
  end

  assign alu_data1     = fwd_rs;
  assign alu_data2     = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = aluop_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expected outputs are queued as
// stimulus is applied and popped/compared once the DUT presents them.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rt, id_alusrc, id_regwrite, id_memread, id_memwrite;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]  id_aluop;
  logic        flush;
  logic        exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        stall;
  logic [31:0] alu_data1, alu_data2, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0]  ex_rd;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sd;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        stall;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .stall(stall), .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_rd(ex_rd), .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] sd, input logic [3:0] op,
                              input logic [4:0] rd, input logic valid, input logic rw,
                              input logic mr, input logic mw, input logic st);
    obs_t o;
    o.d1 = d1; o.d2 = d2; o.sd = sd; o.op = op; o.rd = rd;
    o.valid = valid; o.rw = rw; o.mr = mr; o.mw = mw; o.stall = st;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(alu_data1, alu_data2, ex_store_data, alu_op, ex_rd,
              ex_valid, ex_regwrite, ex_memread, ex_memwrite, stall);
  endfunction

  task automatic push_exp(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    obs_t  e, o;
    string t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=none required=entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observe();
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed d1=%h d2=%h sd=%h op=%h rd=%0d v=%b rw=%b mr=%b mw=%b st=%b required d1=%h d2=%h sd=%h op=%h rd=%0d v=%b rw=%b mr=%b mw=%b st=%b",
             t, o.d1, o.d2, o.sd, o.op, o.rd, o.valid, o.rw, o.mr, o.mw, o.stall,
             e.d1, e.d2, e.sd, e.op, e.rd, e.valid, e.rw, e.mr, e.mw, e.stall);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0; id_aluop = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; flush = 0;
  endtask

  task automatic drive_fwd_off();
    exm_regwrite = 0; exm_rd = 0; exm_result = 0;
    mwb_regwrite = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                             input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [31:0] imm, input logic alusrc, input logic [3:0] op,
                             input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rs = rs; id_rt = rt; id_uses_rt = uses_rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alusrc = alusrc; id_aluop = op;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  // lw r5, 4(r2) with r2 = 0x100
  task automatic drive_lw();
    drive_instr(5'd2, 5'd0, 1'b0, 5'd5, 32'h100, 32'h0, 32'h4, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
  endtask

  // sub r6 = r5 - r1, stale r5 from the register file, r1 = 0x10
  task automatic drive_sub();
    drive_instr(5'd5, 5'd1, 1'b1, 5'd6, 32'hBAD, 32'h10, 32'h0, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    drive_fwd_off();
    #1;
    push_exp("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_out();
    #1 rst_n = 1;

    // Load-use: lw captured, dependent sub in decode raises stall
    drive_lw();
    tick();
    drive_sub();
    push_exp("lw_capture_stall", mk(32'h100, 32'h4, 0, 4'h0, 5'd5, 1, 1, 1, 0, 1));
    #1 check_out();
    tick();
    mwb_regwrite = 1; mwb_rd = 5'd5; mwb_result = 32'h30;
    push_exp("load_use_bubble", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_out();
    tick();
    drive_fwd_off();
    push_exp("load_use_sub", mk(32'h30, 32'h10, 32'h10, 4'h1, 5'd6, 1, 1, 0, 0, 0));
    #1 check_out();

    // ADD back-to-back with EX/MEM forwarding
    drive_instr(5'd1, 5'd2, 1'b1, 5'd3, 32'h8, 32'h8, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    drive_instr(5'd3, 5'd2, 1'b1, 5'd4, 32'hBAD, 32'h5, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    push_exp("add_r3", mk(32'h8, 32'h8, 32'h8, 4'h0, 5'd3, 1, 1, 0, 0, 0));
    #1 check_out();
    tick();
    exm_regwrite = 1; exm_rd = 5'd3; exm_result = 32'h10;
    push_exp("add_fwd_exm", mk(32'h10, 32'h5, 32'h5, 4'h0, 5'd4, 1, 1, 0, 0, 0));
    #1 check_out();

    // Dual match: EX/MEM beats MEM/WB; then MEM/WB alone; r0 never forwarded
    drive_instr(5'd7, 5'd0, 1'b0, 5'd8, 32'h1234, 32'h0, 32'h0, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    exm_regwrite = 1; exm_rd = 5'd7; exm_result = 32'hAAAA_0000;
    mwb_regwrite = 1; mwb_rd = 5'd7; mwb_result = 32'h5555_0000;
    push_exp("dual_exm_wins", mk(32'hAAAA_0000, 0, 0, 4'h2, 5'd8, 1, 1, 0, 0, 0));
    #1 check_out();
    exm_regwrite = 0;
    push_exp("mwb_only", mk(32'h5555_0000, 0, 0, 4'h2, 5'd8, 1, 1, 0, 0, 0));
    #1 check_out();
    drive_instr(5'd0, 5'd0, 1'b1, 5'd9, 32'h77, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    exm_regwrite = 1; exm_rd = 5'd0; exm_result = 32'hAAAA_0000;
    mwb_regwrite = 1; mwb_rd = 5'd0; mwb_result = 32'h5555_0000;
    tick();
    push_exp("r0_no_fwd", mk(32'h77, 0, 0, 4'h0, 5'd9, 1, 1, 0, 0, 0));
    #1 check_out();

    // Flush coincident with load-use hazard
    drive_fwd_off();
    drive_lw();
    tick();
    drive_sub();
    flush = 1;
    push_exp("flush_hz_no_stall", mk(32'h100, 32'h4, 0, 4'h0, 5'd5, 1, 1, 1, 0, 0));
    #1 check_out();
    tick();
    drive_idle();
    push_exp("flush_bubble", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_out();

    // Store with immediate operand and forwarded store data
    drive_instr(5'd1, 5'd9, 1'b1, 5'd0, 32'h40, 32'h1111, 32'h8, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    exm_regwrite = 1; exm_rd = 5'd9; exm_result = 32'hDEAD_BEEF;
    push_exp("sw_imm_store", mk(32'h40, 32'h8, 32'hDEAD_BEEF, 4'h0, 5'd0, 1, 0, 0, 1, 0));
    #1 check_out();

    // id_valid low captures a bubble even with live-looking fields
    drive_instr(5'd1, 5'd2, 1'b1, 5'd12, 32'h99, 32'h98, 32'h0, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0);
    id_valid = 0;
    drive_fwd_off();
    tick();
    push_exp("invalid_bubble", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_out();

    // Asynchronous reset in the middle of a stall
    drive_lw();
    tick();
    drive_sub();
    push_exp("lw_stall_again", mk(32'h100, 32'h4, 0, 4'h0, 5'd5, 1, 1, 1, 0, 1));
    #1 check_out();
    #1 rst_n = 0;
    push_exp("async_reset_mid_stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_out();
    #1 rst_n = 1;

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
